// File: rtl/cr_isf_ia_ctl_pkg.sv
// Shared types for the ISF input-FIFO indirect-access controller:
// command opcodes, completion status codes and controller states.
package cr_isf_ia_ctlPKG;

    typedef enum logic [3:0] {
        IA_NOP       = 4'd0,
        IA_READ      = 4'd1,
        IA_WRITE     = 4'd2,
        IA_CLEAR_ALL = 4'd3
    } ia_op_e;

    typedef enum logic [1:0] {
        IA_OK       = 2'd0,
        IA_REJECTED = 2'd1,
        IA_BAD_ADDR = 2'd2,
        IA_BAD_OP   = 2'd3
    } ia_code_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2,
        S_CLR    = 2'd3
    } ia_state_e;

endpackage

// File: rtl/cr_isf_ia_arb.sv
// RAM port arbiter: the datapath wins by default; after FORCE_LIMIT-1
// consecutive denials the indirect-access path takes a forced slot.
module cr_isf_ia_arb #(
    parameter int FORCE_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ia_req,
    input  logic dp_req,
    output logic ia_grant,
    output logic dp_stall
);

    localparam int CNT_W = (FORCE_LIMIT > 2) ? $clog2(FORCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FORCE_LIMIT - 1);

    logic [CNT_W-1:0] deny_cnt_q, deny_cnt_d;

    always_comb begin
        ia_grant   = ia_req & (~dp_req | (deny_cnt_q == CNT_LAST));
        dp_stall   = dp_req & ia_grant;
        deny_cnt_d = '0;
        if (ia_req && !ia_grant) begin
            deny_cnt_d = deny_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deny_cnt_q <= '0;
        end else begin
            deny_cnt_q <= deny_cnt_d;
        end
    end

endmodule

// File: rtl/cr_isf_ia_ctl.sv
// Indirect-access controller for the ISF input FIFO RAM, sharing the port
// with the datapath. Define CR_ISF_IA_CLEAR_ALL_EN to support CLEAR_ALL (op 3).
module cr_isf_ia_ctl
    import cr_isf_ia_ctlPKG::*;
#(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 96,
    parameter int FORCE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_stb,
    input  logic [3:0]        cfg_op,
    input  logic [ADDR_W:0]   cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ia_busy,
    output logic [1:0]        ia_code,
    output logic [DATA_W-1:0] ia_rdata
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    ia_state_e         state_q, state_d;
    ia_op_e            op_q, op_d;
    ia_code_e          code_q, code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              ia_req, ia_grant;

`ifdef CR_ISF_IA_CLEAR_ALL_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    assign ia_req = (state_q == S_REQ) || (state_q == S_CLR);

    cr_isf_ia_arb #(
        .FORCE_LIMIT (FORCE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ia_req   (ia_req),
        .dp_req   (dp_req),
        .ia_grant (ia_grant),
        .dp_stall (dp_stall)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        code_d  = code_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
`ifdef CR_ISF_IA_CLEAR_ALL_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_stb) begin
                    if (cfg_op == IA_NOP) begin
                        code_d = IA_OK;
                    end else if (cfg_op == IA_READ || cfg_op == IA_WRITE) begin
                        if (cfg_addr >= DEPTH_W) begin
                            code_d = IA_BAD_ADDR;
                        end else begin
                            op_d    = ia_op_e'(cfg_op);
                            addr_d  = cfg_addr[ADDR_W-1:0];
                            wdata_d = cfg_wdata;
                            busy_d  = 1'b1;
                            state_d = S_REQ;
                        end
`ifdef CR_ISF_IA_CLEAR_ALL_EN
                    end else if (cfg_op == IA_CLEAR_ALL) begin
                        op_d      = IA_CLEAR_ALL;
                        clr_cnt_d = '0;
                        busy_d    = 1'b1;
                        state_d   = S_CLR;
`endif
                    end else begin
                        code_d = IA_BAD_OP;
                    end
                end
            end
            S_REQ: begin
                if (ia_grant) begin
                    if (op_q == IA_WRITE) begin
                        busy_d  = 1'b0;
                        code_d  = IA_OK;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                rdata_d = ram_rdata;
                busy_d  = 1'b0;
                code_d  = IA_OK;
                state_d = S_IDLE;
            end
`ifdef CR_ISF_IA_CLEAR_ALL_EN
            S_CLR: begin
                if (ia_grant) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        busy_d  = 1'b0;
                        code_d  = IA_OK;
                        state_d = S_IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // A command arriving while one is running is dropped and reported.
        if (cfg_stb && state_q != S_IDLE) begin
            code_d = IA_REJECTED;
        end
    end

    always_comb begin
        ram_en    = dp_req;
        ram_we    = dp_req & dp_we;
        ram_addr  = dp_addr;
        ram_wdata = dp_wdata;
        if (ia_grant) begin
            ram_en    = 1'b1;
            ram_we    = (op_q == IA_WRITE);
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
`ifdef CR_ISF_IA_CLEAR_ALL_EN
            if (state_q == S_CLR) begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= IA_NOP;
            code_q  <= IA_OK;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CR_ISF_IA_CLEAR_ALL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    assign ia_busy  = busy_q;
    assign ia_code  = code_q;
    assign ia_rdata = rdata_q;

endmodule

// File: tb/tb_cr_isf_ia_ctl.sv
// Directed bench for cr_isf_ia_ctl with a behavioural single-port RAM;
// inputs change and outputs are sampled on the falling clock edge.
module tb_cr_isf_ia_ctl;
    import cr_isf_ia_ctlPKG::*;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 96;
    localparam int FL     = 16;

    localparam logic [DATA_W-1:0] PAT1 = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [DATA_W-1:0] PAT2 = 96'h0123_4567_89AB_CDEF_5A5A_F00D;
    localparam logic [DATA_W-1:0] PAT3 = 96'hDEAD_BEEF_CAFE_1234_8765_4321;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_stb;
    logic [3:0]        cfg_op;
    logic [ADDR_W:0]   cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              dp_req, dp_we;
    logic [ADDR_W-1:0] dp_addr;
    logic [DATA_W-1:0] dp_wdata;
    logic              dp_stall, ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              ia_busy;
    logic [1:0]        ia_code;
    logic [DATA_W-1:0] ia_rdata;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr3_seen = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cr_isf_ia_ctl #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FORCE_LIMIT (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_stb   (cfg_stb),
        .cfg_op    (cfg_op),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .dp_req    (dp_req),
        .dp_we     (dp_we),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .dp_stall  (dp_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ia_busy   (ia_busy),
        .ia_code   (ia_code),
        .ia_rdata  (ia_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
        if (ram_en && ram_we && ram_addr == 9'd3) wr3_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [ADDR_W:0] addr, input logic [DATA_W-1:0] wd);
        @(negedge clk);
        cfg_stb   = 1'b1;
        cfg_op    = op;
        cfg_addr  = addr;
        cfg_wdata = wd;
        @(negedge clk);
        cfg_stb = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp_cycles;
        int good;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_rdata = '0;
        rst_n = 1'b0; cfg_stb = 1'b0; cfg_op = '0; cfg_addr = '0; cfg_wdata = '0;
        dp_req = 1'b0; dp_we = 1'b0; dp_addr = '0; dp_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", ia_busy, 0);
        check("rst_code", ia_code, 0);
        check("rst_rdata", ia_rdata, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_stall", dp_stall, 0);
        rst_n = 1'b1;

        // Uncontended WRITE then READ back.
        cmd(IA_WRITE, 10'd5, PAT1);
        check("wr_busy", ia_busy, 1);
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 5);
        check("wr_ram_wdata", ram_wdata, PAT1);
        next_cyc();
        check("wr_done_busy", ia_busy, 0);
        check("wr_done_code", ia_code, IA_OK);
        check("wr_done_ram_en", ram_en, 0);

        cmd(IA_READ, 10'd5, '0);
        check("rd_ram_en", ram_en, 1);
        check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, 5);
        next_cyc();
        check("rd_wait_busy", ia_busy, 1);
        next_cyc();
        check("rd_done_busy", ia_busy, 0);
        check("rd_done_rdata", ia_rdata, PAT1);
        check("rd_done_code", ia_code, IA_OK);

        // Bad address, reserved op, NOP.
        cmd(IA_READ, 10'd512, '0);
        check("badaddr_code", ia_code, IA_BAD_ADDR);
        check("badaddr_busy", ia_busy, 0);
        check("badaddr_ram_en", ram_en, 0);
        cmd(IA_WRITE, 10'd1023, PAT3);
        check("badaddr_wr_code", ia_code, IA_BAD_ADDR);
        check("badaddr_wr_ram_en", ram_en, 0);
        cmd(4'd7, 10'd1, '0);
        check("badop_code", ia_code, IA_BAD_OP);
        check("badop_busy", ia_busy, 0);
        cmd(IA_NOP, 10'd0, '0);
        check("nop_code", ia_code, IA_OK);

        // Contended READ: datapath holds the port until the forced slot.
        cmd(IA_WRITE, 10'd9, PAT2);
        next_cyc();
        @(negedge clk);
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 9'd7;
        cfg_stb = 1'b1; cfg_op = IA_READ; cfg_addr = 10'd9;
        @(negedge clk);
        cfg_stb = 1'b0;
        #1;
        dp_cycles = 0;
        for (int i = 0; i < FL + 4; i++) begin
            if (dp_stall) break;
            if (ram_en && ram_addr == 9'd7) dp_cycles++;
            next_cyc();
        end
        check("force_stall", dp_stall, 1);
        check("force_dp_cycles", dp_cycles, FL - 1);
        check("force_ram_addr", ram_addr, 9);
        next_cyc();
        check("force_rdwait_stall", dp_stall, 0);
        check("force_rdwait_addr", ram_addr, 7);
        next_cyc();
        check("force_rdata", ia_rdata, PAT2);
        check("force_busy", ia_busy, 0);

        // Command while busy is rejected; the running READ still finishes.
        cmd(IA_READ, 10'd5, '0);
        @(negedge clk);
        cfg_stb = 1'b1; cfg_op = IA_WRITE; cfg_addr = 10'd3; cfg_wdata = PAT3;
        @(negedge clk);
        cfg_stb = 1'b0;
        #1;
        check("rej_code", ia_code, IA_REJECTED);
        check("rej_busy", ia_busy, 1);
        for (int i = 0; i < 40; i++) begin
            if (!ia_busy) break;
            next_cyc();
        end
        check("rej_done_busy", ia_busy, 0);
        check("rej_done_code", ia_code, IA_OK);
        check("rej_done_rdata", ia_rdata, PAT1);
        check("rej_no_write", wr3_seen, 0);
        dp_req = 1'b0; dp_addr = '0;

        // Reset while in RDWAIT.
        cmd(4'd7, 10'd0, '0);
        check("pre_rst_code", ia_code, IA_BAD_OP);
        cmd(IA_READ, 10'd9, '0);
        next_cyc();
        check("pre_rst_busy", ia_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_busy", ia_busy, 0);
        check("midrst_code", ia_code, 0);
        check("midrst_rdata", ia_rdata, 0);
        check("midrst_ram_en", ram_en, 0);
        dp_req = 1'b1; dp_we = 1'b1; dp_addr = 9'd20; dp_wdata = PAT3;
        #1;
        check("pass_ram_en", ram_en, 1);
        check("pass_ram_we", ram_we, 1);
        check("pass_ram_addr", ram_addr, 20);
        check("pass_ram_wdata", ram_wdata, PAT3);
        check("pass_stall", dp_stall, 0);
        next_cyc();
        dp_req = 1'b0; dp_we = 1'b0; dp_addr = '0; dp_wdata = '0;

`ifdef CR_ISF_IA_CLEAR_ALL_EN
        cmd(IA_CLEAR_ALL, 10'd0, '0);
        good = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram_en && ram_we && ram_addr == i[ADDR_W-1:0] && ram_wdata == '0 && ia_busy) good++;
            if (i != DEPTH - 1) next_cyc();
        end
        check("clr_writes", good, DEPTH);
        check("clr_last_busy", ia_busy, 1);
        next_cyc();
        check("clr_done_busy", ia_busy, 0);
        check("clr_done_code", ia_code, IA_OK);
        check("clr_done_ram_en", ram_en, 0);
        cmd(IA_READ, 10'd5, '0);
        next_cyc();
        next_cyc();
        check("clr_readback", ia_rdata, 0);
`else
        good = 0;
        cmd(IA_CLEAR_ALL, 10'd0, '0);
        check("clr_badop_code", ia_code, IA_BAD_OP);
        check("clr_badop_busy", ia_busy, 0);
        check("clr_badop_ram_en", ram_en, good);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cr_isf_ia_ctl.md
# cr_isf_ia_ctl

Indirect-access controller and port arbiter for the ISF input FIFO's single-port RAM. It sits between the ISF register block and the RAM. It decodes an indirect-access command (op + address + write data) issued by a register write, and sequences the RAM access. It shares the RAM port with the datapath FIFO logic: the datapath has priority, and an anti-starvation counter guarantees the register path eventually gets a slot. It reports busy/status/read-data back for register readout.

## Interface
- `DEPTH`, 512: RAM entries.
- `ADDR_W`, 9: RAM address width; must equal clog2(DEPTH).
- `DATA_W`, 96: RAM word width (three 32-bit parts).
- `FORCE_LIMIT`, 16: consecutive denied cycles before the IA path takes a forced slot; must be ≥ 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `cfg_stb`  in  1  one-cycle IA command strobe (config register written).
- `cfg_op`  in  4  0 NOP, 1 READ, 2 WRITE, 3 CLEAR_ALL, others reserved.
- `cfg_addr`  in  ADDR_W+1  target address; an extra MSB allows out-of-range detection.
- `cfg_wdata`  in  DATA_W  write data; sampled with `cfg_stb`.
- `dp_req`  in  1  datapath RAM request this cycle.
- `dp_we`  in  1  datapath write enable.
- `dp_addr`  in  ADDR_W  datapath address.
- `dp_wdata`  in  DATA_W  datapath write data.
- `dp_stall`  out  1  datapath request not performed this cycle; datapath must hold it.
- `ram_en`  out  1  RAM access.
- `ram_we`  out  1  RAM write.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid 1 cycle after a read.
- `ia_busy`  out  1  command in progress.
- `ia_code`  out  2  0 OK, 1 REJECTED, 2 BAD_ADDR, 3 BAD_OP.
- `ia_rdata`  out  DATA_W  last READ result.

## Operation
- States: IDLE, REQ, RDWAIT, CLR.
- IDLE, `cfg_stb`:
  - NOP → stay IDLE, code 0.
  - op > 3 (or 3 with the feature compiled out) → code 3, stay IDLE.
  - READ/WRITE with `cfg_addr` ≥ DEPTH → code 2, stay IDLE.
  - Otherwise latch op/addr/wdata, set busy, go to REQ (READ/WRITE) or CLR (CLEAR_ALL, address counter = 0).
- `cfg_stb` while busy → command ignored; `ia_code` = 1 at once; completion of the running command overwrites the code.
- REQ/CLR arbitration, evaluated each cycle:
  - IA owns the port if `dp_req`=0, or if the denied counter = FORCE_LIMIT−1.
  - Otherwise the datapath owns it and the denied counter increments.
  - The counter clears whenever IA owns the port.
  - `dp_stall` = `dp_req` & IA-owns.
  - With no IA request pending, `dp_*` passes straight through to `ram_*`; `dp_stall`=0.
- REQ, IA owns:
  - WRITE → RAM write, then IDLE, busy 0, code 0.
  - READ → RAM read, then RDWAIT.
- RDWAIT: capture `ram_rdata` into `ia_rdata`, busy 0, code 0, go to IDLE. The datapath owns the port freely in this cycle.
- CLR, IA owns: write zero at the counter address, then increment. After writing DEPTH−1 → IDLE, busy 0, code 0. The counter wraps nothing; it stops at DEPTH−1.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-command abandons it; any in-flight read data is discarded.
- `cfg_stb` at cycle N → `ia_busy` = 1 at N+1; the earliest RAM access is at N+1.
- WRITE, uncontended: busy falls at N+2.
- READ, uncontended: `ia_rdata` valid and busy low at N+3.
- Worst-case IA wait: FORCE_LIMIT cycles per access.
- CLEAR_ALL, uncontended: DEPTH cycles of writes.
- `ram_*` and `dp_stall` are combinational from the state and `dp_*`. `ia_*` outputs are registered.

## Configuration
- `CR_ISF_IA_CLEAR_ALL_EN`:
  - Defined → op 3 is supported, with the CLR state and its address counter.
  - Undefined → no CLR logic; op 3 returns code 3 (BAD_OP), like any other reserved op.

## Structure
- Shared package `cr_isf_ia_ctlPKG`: op enum (`IA_NOP`, `IA_READ`, `IA_WRITE`, `IA_CLEAR_ALL`), status-code enum, state enum.
- The anti-starvation arbiter is natural as the sub-module `cr_isf_ia_arb`. It holds the denied counter and the grant/stall logic.

## Test plan
- WRITE to addr 5, data 0xA5…, idle datapath → `ram_we` at N+1, busy low at N+2; a following READ of 5 returns the same data at its +3 cycle, code 0.
- `dp_req` held high continuously, IA READ issued, FORCE_LIMIT=16 → 15 datapath accesses, IA access on the 16th cycle with `dp_stall`=1 for exactly that cycle.
- READ with `cfg_addr` = DEPTH → code 2, busy never rises, no RAM access. Op 7 → code 3.
- `cfg_stb` during a stalled READ → code 1 immediately; the original READ completes and sets code 0 with correct `ia_rdata`.
- CLEAR_ALL (macro defined), DEPTH=512, idle datapath → 512 consecutive zero writes at addrs 0..511, busy low at N+513. With the macro undefined → code 3.
- `rst_n` low for one cycle while in RDWAIT → all outputs 0 next cycle, `ia_rdata` not updated, datapath passthrough resumes.
